// File: rtl/mem_bus_master_if.sv
// mem_bus_master_if
//   Client handshake and memory control pins of mem_bus_master.
//   master modport: seen from mem_bus_master (accepts requests, drives memory
//   control pins). slave modport: seen from the client/memory side.
//   Signals:
//     req_valid/req_ready/req_write/req_addr/req_wdata  request channel
//     resp_valid/resp_rdata/resp_err                     response strobe
//     mem_instruction/mem_address                        memory control (1 = read)
//   The shared tri-state data bus is not carried here; it is a plain inout
//   port on mem_bus_master so tri-state resolution stays at module level.
interface mem_bus_master_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic                  mem_instruction;
    logic [ADDR_WIDTH-1:0] mem_address;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_instruction, mem_address
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_instruction, mem_address
    );
endinterface

// File: rtl/mem_bus_master.sv
// mem_bus_master
//   Initiator for a single-port synchronous memory with a shared tri-state
//   data bus. Takes read/write requests over valid/ready, sequences the
//   memory instruction/address/data pins and returns a one-cycle response.
//   Ports:
//     clock, reset_n  rising-edge clock, async active-low reset
//     bus             mem_bus_master_if.master (request, response, memory control)
//     mem_data        shared data bus; driven only while mem_instruction is 0
//   Build option:
//     MEM_BUS_MASTER_WRITE_VERIFY_EN  read back every write and flag a mismatch
//                                     on resp_err; otherwise resp_err is 0.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   IDLE        | req_ready high, memory held in read (no spurious writes)
//   WRITE       | instruction 0, bus driven; memory writes on the next edge
//   RD_ISSUE    | instruction 1; memory registers memory[addr] on next edge
//   RD_CAPTURE  | memory drives the bus; sampled into resp_rdata
//   VFY_ISSUE   | (verify build) read-back of the written address issued
//   VFY_CAPTURE | (verify build) read-back sampled and compared
module mem_bus_master #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    mem_bus_master_if.master      bus,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);

`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WRITE       = 3'd1,
        RD_ISSUE    = 3'd2,
        RD_CAPTURE  = 3'd3,
        VFY_ISSUE   = 3'd4,
        VFY_CAPTURE = 3'd5
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE      = 2'd1,
        RD_ISSUE   = 2'd2,
        RD_CAPTURE = 2'd3
    } state_t;
`endif

    state_t                state_q, state_d;
    logic                  instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
    logic                  err_q, err_d;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            instr_q      <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
            err_q        <= err_d;
`endif
        end
    end

    // instruction defaults to read every cycle; only the IDLE->WRITE
    // transition pulls it low, so it is 0 for exactly the WRITE cycle.
    always_comb begin
        state_d      = state_q;
        instr_d      = 1'b1;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;
`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
        err_d        = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (bus.req_write) begin
                        state_d = WRITE;
                        instr_d = 1'b0;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            WRITE: begin
`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
                state_d = VFY_ISSUE;
`else
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                rdata_d      = '0;
`endif
            end
            RD_ISSUE: begin
                state_d = RD_CAPTURE;
            end
            RD_CAPTURE: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                rdata_d      = mem_data;
`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
                err_d        = 1'b0;
`endif
            end
`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
            VFY_ISSUE: begin
                state_d = VFY_CAPTURE;
            end
            VFY_CAPTURE: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                rdata_d      = mem_data;
                err_d        = (mem_data != wdata_q);
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_ready       = (state_q == IDLE);
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_rdata      = rdata_q;
    assign bus.mem_instruction = instr_q;
    assign bus.mem_address     = addr_q;
`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
    assign bus.resp_err        = err_q;
`else
    assign bus.resp_err        = 1'b0;
`endif

    // Ownership follows the registered instruction: the memory only drives
    // while instruction is 1, so the two drivers never overlap.
    assign mem_data = instr_q ? {DATA_WIDTH{1'bz}} : wdata_q;

endmodule

// File: tb/tb_mem_bus_master.sv
module tb_mem_bus_master;
    logic        clock;
    logic        reset_n;
    wire  [15:0] mem_data;

    mem_bus_master_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) bus ();

    mem_bus_master #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .bus      (bus.master),
        .mem_data (mem_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: writes on every edge with instruction 0, otherwise
    // registers memory[addr] and drives it onto the bus while instruction 1.
    logic [15:0] mem [0:4095];
    logic [15:0] mem_rd_q;
    logic [15:0] stuck_mask;

    always @(posedge clock) begin
        if (!bus.mem_instruction)
            mem[bus.mem_address] <= mem_data | stuck_mask;
        else
            mem_rd_q <= mem[bus.mem_address];
    end

    assign mem_data = bus.mem_instruction ? mem_rd_q : 16'bz;

    int n_checks;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [11:0] a, input logic [15:0] d, input string tag);
        chk({tag, " req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = ~a;
        bus.req_wdata = ~d;
        chk({tag, " instr in WRITE"}, {31'd0, bus.mem_instruction}, 32'd0);
        chk({tag, " address"}, {20'd0, bus.mem_address}, {20'd0, a});
        chk({tag, " bus data"}, {16'd0, mem_data}, {16'd0, d});
        chk({tag, " resp_valid early"}, {31'd0, bus.resp_valid}, 32'd0);
`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
        @(negedge clock);
        chk({tag, " instr in VFY_ISSUE"}, {31'd0, bus.mem_instruction}, 32'd1);
        chk({tag, " vfy address"}, {20'd0, bus.mem_address}, {20'd0, a});
        @(negedge clock);
        chk({tag, " resp_valid in VFY_CAPTURE"}, {31'd0, bus.resp_valid}, 32'd0);
        @(negedge clock);
        chk({tag, " resp_rdata readback"}, {16'd0, bus.resp_rdata}, {16'd0, d | stuck_mask});
        chk({tag, " resp_err"}, {31'd0, bus.resp_err}, {31'd0, ((d | stuck_mask) != d)});
`else
        @(negedge clock);
        chk({tag, " resp_err"}, {31'd0, bus.resp_err}, 32'd0);
`endif
        chk({tag, " resp_valid"}, {31'd0, bus.resp_valid}, 32'd1);
        chk({tag, " instr after"}, {31'd0, bus.mem_instruction}, 32'd1);
    endtask

    task automatic do_read(input logic [11:0] a, input logic [15:0] exp, input string tag);
        chk({tag, " req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = a;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        bus.req_write = 1'b1;
        bus.req_addr  = ~a;
        chk({tag, " instr in RD_ISSUE"}, {31'd0, bus.mem_instruction}, 32'd1);
        chk({tag, " address"}, {20'd0, bus.mem_address}, {20'd0, a});
        chk({tag, " resp_valid early"}, {31'd0, bus.resp_valid}, 32'd0);
        @(negedge clock);
        chk({tag, " bus data"}, {16'd0, mem_data}, {16'd0, exp});
        chk({tag, " resp_valid in CAPTURE"}, {31'd0, bus.resp_valid}, 32'd0);
        @(negedge clock);
        chk({tag, " resp_valid"}, {31'd0, bus.resp_valid}, 32'd1);
        chk({tag, " resp_rdata"}, {16'd0, bus.resp_rdata}, {16'd0, exp});
        chk({tag, " resp_err"}, {31'd0, bus.resp_err}, 32'd0);
        bus.req_write = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        stuck_mask    = 16'h0000;
        mem_rd_q      = 16'h0000;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        reset_n       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 12'h000;
        bus.req_wdata = 16'h0000;

        // reset values
        repeat (2) @(negedge clock);
        chk("rst instr",      {31'd0, bus.mem_instruction}, 32'd1);
        chk("rst address",    {20'd0, bus.mem_address}, 32'd0);
        chk("rst resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst resp_rdata", {16'd0, bus.resp_rdata}, 32'd0);
        chk("rst resp_err",   {31'd0, bus.resp_err}, 32'd0);
        chk("rst req_ready",  {31'd0, bus.req_ready}, 32'd1);
        reset_n = 1'b1;
        @(negedge clock);

        // reset asserted in the middle of a write
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 12'h010;
        bus.req_wdata = 16'h0055;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        chk("midrst instr before", {31'd0, bus.mem_instruction}, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("midrst instr",      {31'd0, bus.mem_instruction}, 32'd1);
        chk("midrst address",    {20'd0, bus.mem_address}, 32'd0);
        chk("midrst resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("midrst req_ready",  {31'd0, bus.req_ready}, 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("midrst resp_valid after", {31'd0, bus.resp_valid}, 32'd0);
        chk("midrst req_ready after",  {31'd0, bus.req_ready}, 32'd1);
        @(negedge clock);
        chk("midrst resp_valid later", {31'd0, bus.resp_valid}, 32'd0);

        // back-to-back writes
        do_write(12'h1A1, 16'd81, "wr1");
        do_write(12'h123, 16'd43, "wr2");
        @(negedge clock);
        chk("wr2 resp_valid one cycle", {31'd0, bus.resp_valid}, 32'd0);
        chk("model mem[1A1]", {16'd0, mem[12'h1A1]}, 32'd81);
        chk("model mem[123]", {16'd0, mem[12'h123]}, 32'd43);

        // reads
        do_read(12'h1A1, 16'd81, "rd1");
        do_read(12'h123, 16'd43, "rd2");

        // overwrite, then read accepted in the resp_valid cycle
        @(negedge clock);
        do_write(12'h1A1, 16'd24, "wr3");
        do_read(12'h1A1, 16'd24, "rd3");
        @(negedge clock);
        chk("rd3 rdata hold", {16'd0, bus.resp_rdata}, 32'd24);
        chk("rd3 resp_valid pulse", {31'd0, bus.resp_valid}, 32'd0);

        // address boundaries
        do_write(12'h000, 16'hFFFF, "wr_lo");
        do_write(12'hFFF, 16'h0001, "wr_hi");
        do_read(12'h000, 16'hFFFF, "rd_lo");
        do_read(12'hFFF, 16'h0001, "rd_hi");
        chk("model mem[001]", {16'd0, mem[12'h001]}, 32'd0);
        chk("model mem[FFE]", {16'd0, mem[12'hFFE]}, 32'd0);
        chk("model mem[123] kept", {16'd0, mem[12'h123]}, 32'd43);
        chk("model mem[1A1] kept", {16'd0, mem[12'h1A1]}, 32'd24);

`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
        // verified writes, clean and with a stuck bit in the memory
        do_write(12'h1A1, 16'd35, "vfy_ok");
        stuck_mask = 16'h0100;
        do_write(12'h200, 16'd35, "vfy_stuck");
        stuck_mask = 16'h0000;
        @(negedge clock);
        do_read(12'h200, 16'h0123, "rd_stuck");
`endif

        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
